h264_fwd_tq: RTL and testbench
==============================

H264_FWD_TQ -- requirements
Module: h264_fwd_tq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous reset, active-low (0 = reset).
REQ-003 SHALL have port res_valid_i, input, 1 bit: a 4x4 residual block is presented.
REQ-004 SHALL have port res_i, input, [0:3][0:3] x 9 bit signed: residual block from the intra 4x4 stage.
REQ-005 SHALL have port blk_idx_i, input, 4 bits: 4x4 block index within the macroblock.
REQ-006 SHALL have port qp_i, input, 6 bits: quantization parameter, sampled on acceptance.
REQ-007 SHALL have port res_ready_o, output, 1 bit: block can be accepted this cycle.
REQ-008 SHALL have port coef_valid_o, output, 1 bit: quantized block is valid.
REQ-009 SHALL have port coef_o, output, [0:3][0:3] x 16 bit signed: quantized coefficients.
REQ-010 SHALL have port coef_blk_idx_o, output, 4 bits: captured blk_idx_i.
REQ-011 SHALL have port coef_nz_o, output, 5 bits: count of nonzero coefficients (0..16).
REQ-012 SHALL have port coef_ready_i, input, 1 bit: downstream accepts the output block.

Function
REQ-013 SHALL implement states IDLE, ROW, COL, QUANT, OUT.
REQ-014 SHALL assert res_ready_o only in IDLE.
REQ-015 SHALL accept a block when res_valid_i && res_ready_o: capture res_i, blk_idx_i and qp_i (clamped to 51 if >51), then go to ROW.
REQ-016 SHALL ignore res_valid_i in every state other than IDLE.
REQ-017 SHALL spend exactly 4 cycles each in ROW, COL and QUANT, processing one row or column per cycle with a 2-bit counter that wraps 3->0 on state exit.
REQ-018 SHALL compute T = X*C^T in ROW and W = C*T in COL, with C = [[1,1,1,1],[2,1,-1,-2],[1,-1,-1,1],[1,-2,2,-1]].
REQ-019 SHALL hold T at >=12 bits signed and W at >=15 bits signed; no saturation is needed or permitted before quantization.
REQ-020 SHALL compute each Z[i][j] in QUANT as sign(W)*((|W|*MF + f) >> qbits), where qbits = 15 + qp/6 and f = floor(2^qbits / 3).
REQ-021 SHALL select MF by qp%6 and position class: a (i,j both even), b (both odd), c (otherwise). Table rows for qp%6 = 0..5 give (a,b,c): (13107,5243,8066), (11916,4660,7490), (10082,4194,6554), (9362,3647,5825), (8192,3355,5243), (7282,2893,4559).
REQ-022 SHALL derive qp/6 and qp%6 by lookup or iterative logic that completes before QUANT; no combinational divider is allowed on the clk path.
REQ-023 SHALL give a zero input W a zero output; no negative zero exists.
REQ-024 SHALL enter OUT after the fourth QUANT cycle, with coef_valid_o=1 registered exactly 12 cycles after the acceptance edge.
REQ-025 SHALL hold coef_o, coef_blk_idx_o and coef_nz_o stable in OUT while coef_ready_i=0.
REQ-026 SHALL, on coef_valid_o && coef_ready_i, return to IDLE and drop coef_valid_o next cycle; res_ready_o rises that same next cycle, with no same-cycle bypass.
REQ-027 SHALL accumulate coef_nz_o during QUANT so it is valid together with coef_valid_o.

Reset
REQ-028 SHALL, while rst=0, force state IDLE, counters 0, res_ready_o=0, coef_valid_o=0, coef_o all 0, coef_blk_idx_o=0, coef_nz_o=0.
REQ-029 SHALL, when rst asserts mid-operation in any state, abort the block immediately with no output produced.
REQ-030 SHALL assert res_ready_o on the first clk edge after rst deasserts.

Verification
REQ-031 Residual all 0, qp=27 -> after 12 cycles coef_o all 0, coef_nz_o=0.
REQ-032 Residual all 10, qp=27 -> coef_o[0][0]=3, all others 0, coef_nz_o=1.
REQ-033 Residual all -10, qp=27 -> coef_o[0][0]=-3, all others 0, coef_nz_o=1.
REQ-034 Residual all 1, qp=0 -> coef_o[0][0]=6, all others 0. Residual all 1, qp=60 -> behaves as qp=51, coef_o all 0.
REQ-035 Hold coef_ready_i=0 for 5 cycles in OUT while toggling res_valid_i -> outputs constant, res_ready_o=0, no block accepted. Then coef_ready_i=1 -> IDLE next cycle.
REQ-036 Pulse rst=0 during COL -> all outputs 0 immediately. After release, a new block yields a correct result 12 cycles after its acceptance.

Source files
------------

// File: rtl/h264_fwd_tq.sv
// H.264 forward 4x4 integer transform and quantizer.
// One residual block in flight: ROW pass, COL pass, QUANT pass (4 cycles each), then OUT.
module h264_fwd_tq (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         res_valid_i,
    input  logic signed [0:3][0:3][8:0]  res_i,
    input  logic [3:0]                   blk_idx_i,
    input  logic [5:0]                   qp_i,
    output logic                         res_ready_o,
    output logic                         coef_valid_o,
    output logic signed [0:3][0:3][15:0] coef_o,
    output logic [3:0]                   coef_blk_idx_o,
    output logic [4:0]                   coef_nz_o,
    input  logic                         coef_ready_i
);
    typedef enum logic [2:0] {IDLE, ROW, COL, QUANT, OUT} state_t;

    state_t             state, state_nxt;
    logic [1:0]         cnt;
    logic [5:0]         qp_rem;
    logic [3:0]         qp_div;
    logic               accept;

    logic signed [15:0] x [4][4];
    logic signed [15:0] t [4][4];
    logic signed [15:0] w [4][4];
    logic signed [15:0] row_t [4];
    logic signed [15:0] col_w [4];
    logic [15:0]        abs_w [4];
    logic [15:0]        mag [4];
    logic signed [15:0] z [4];
    logic [2:0]         nz_row;

    assign accept = res_valid_i && res_ready_o;

    // One output of the 1-D core transform: result j of C applied to (a0..a3).
    function automatic logic signed [15:0] dct(input logic signed [15:0] a0, a1, a2, a3,
                                               input int unsigned j);
        case (j)
            0:       dct = a0 + a1 + a2 + a3;
            1:       dct = (a0 <<< 1) + a1 - a2 - (a3 <<< 1);
            2:       dct = a0 - a1 - a2 + a3;
            default: dct = a0 - (a1 <<< 1) + (a2 <<< 1) - a3;
        endcase
    endfunction

    // cls: {row odd, col odd}; 00 -> a, 11 -> b, otherwise c.
    function automatic logic [13:0] mf_sel(input logic [2:0] m, input logic [1:0] cls);
        logic [13:0] a, b, c;
        case (m)
            3'd0:    begin a = 14'd13107; b = 14'd5243; c = 14'd8066; end
            3'd1:    begin a = 14'd11916; b = 14'd4660; c = 14'd7490; end
            3'd2:    begin a = 14'd10082; b = 14'd4194; c = 14'd6554; end
            3'd3:    begin a = 14'd9362;  b = 14'd3647; c = 14'd5825; end
            3'd4:    begin a = 14'd8192;  b = 14'd3355; c = 14'd5243; end
            default: begin a = 14'd7282;  b = 14'd2893; c = 14'd4559; end
        endcase
        case (cls)
            2'b00:   mf_sel = a;
            2'b11:   mf_sel = b;
            default: mf_sel = c;
        endcase
    endfunction

    // Rounding offset floor(2^(15+d)/3).
    function automatic logic [21:0] f_sel(input logic [3:0] d);
        case (d)
            4'd1:    f_sel = 22'd21845;
            4'd2:    f_sel = 22'd43690;
            4'd3:    f_sel = 22'd87381;
            4'd4:    f_sel = 22'd174762;
            4'd5:    f_sel = 22'd349525;
            4'd6:    f_sel = 22'd699050;
            4'd7:    f_sel = 22'd1398101;
            4'd8:    f_sel = 22'd2796202;
            default: f_sel = 22'd10922;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ROW;
            ROW:     if (cnt == 2'd3) state_nxt = COL;
            COL:     if (cnt == 2'd3) state_nxt = QUANT;
            QUANT:   if (cnt == 2'd3) state_nxt = OUT;
            OUT:     if (coef_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        for (int unsigned j = 0; j < 4; j++) begin
            row_t[j] = dct(x[cnt][0], x[cnt][1], x[cnt][2], x[cnt][3], j);
            col_w[j] = dct(t[0][cnt], t[1][cnt], t[2][cnt], t[3][cnt], j);
        end
    end

    always_comb begin
        nz_row = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            abs_w[j] = w[cnt][j][15] ? 16'(-w[cnt][j]) : 16'(w[cnt][j]);
            mag[j]   = 16'((32'(abs_w[j]) * 32'(mf_sel(qp_rem[2:0], {cnt[0], j[0]}))
                           + 32'(f_sel(qp_div))) >> (5'd15 + 5'(qp_div)));
            z[j]     = w[cnt][j][15] ? -$signed(mag[j]) : $signed(mag[j]);
            nz_row   = nz_row + 3'(mag[j] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            for (int unsigned r = 0; r < 4; r++)
                for (int unsigned c = 0; c < 4; c++)
                    x[r][c] <= 16'($signed(res_i[r][c]));
        end
        if (state == ROW)
            for (int unsigned j = 0; j < 4; j++) t[cnt][j] <= row_t[j];
        if (state == COL)
            for (int unsigned i = 0; i < 4; i++) w[i][cnt] <= col_w[i];
    end

    // qp/6 and qp%6 by repeated subtraction over the 8 ROW+COL cycles (51 needs 8 steps).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            qp_rem         <= '0;
            qp_div         <= '0;
            res_ready_o    <= 1'b0;
            coef_valid_o   <= 1'b0;
            coef_o         <= '0;
            coef_blk_idx_o <= '0;
            coef_nz_o      <= '0;
        end else begin
            res_ready_o  <= (state_nxt == IDLE);
            coef_valid_o <= (state_nxt == OUT);
            if (state == ROW || state == COL || state == QUANT) cnt <= cnt + 2'd1;
            else                                                cnt <= '0;
            if (state == IDLE && accept) begin
                qp_rem         <= (qp_i > 6'd51) ? 6'd51 : qp_i;
                qp_div         <= '0;
                coef_blk_idx_o <= blk_idx_i;
                coef_nz_o      <= '0;
            end
            if ((state == ROW || state == COL) && qp_rem >= 6'd6) begin
                qp_rem <= qp_rem - 6'd6;
                qp_div <= qp_div + 4'd1;
            end
            if (state == QUANT) begin
                for (int unsigned j = 0; j < 4; j++) coef_o[cnt][j] <= z[j];
                coef_nz_o <= coef_nz_o + {2'b00, nz_row};
            end
        end
    end
endmodule

// File: tb/tb_h264_fwd_tq.sv
// Directed bench for h264_fwd_tq with hand-computed quantized outputs.
module tb_h264_fwd_tq;
    logic                         clk;
    logic                         rst;
    logic                         res_valid_i;
    logic signed [0:3][0:3][8:0]  res_i;
    logic [3:0]                   blk_idx_i;
    logic [5:0]                   qp_i;
    logic                         res_ready_o;
    logic                         coef_valid_o;
    logic signed [0:3][0:3][15:0] coef_o;
    logic [3:0]                   coef_blk_idx_o;
    logic [4:0]                   coef_nz_o;
    logic                         coef_ready_i;

    int vectors = 0;
    int miscompares = 0;
    int exp_z [4][4];
    logic signed [0:3][0:3][8:0] blk_v;

    // x[0][0]=100, qp=28 and x[0][0]=10, qp=5
    int tab_a [4][4] = '{'{1, 2, 1, 1}, '{2, 2, 2, 1}, '{1, 2, 1, 1}, '{1, 1, 1, 0}};
    int tab_b [4][4] = '{'{2, 3, 2, 1}, '{3, 3, 3, 2}, '{2, 3, 2, 1}, '{1, 2, 1, 1}};

    h264_fwd_tq dut (
        .clk            (clk),
        .rst            (rst),
        .res_valid_i    (res_valid_i),
        .res_i          (res_i),
        .blk_idx_i      (blk_idx_i),
        .qp_i           (qp_i),
        .res_ready_o    (res_ready_o),
        .coef_valid_o   (coef_valid_o),
        .coef_o         (coef_o),
        .coef_blk_idx_o (coef_blk_idx_o),
        .coef_nz_o      (coef_nz_o),
        .coef_ready_i   (coef_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic fill(input int v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) blk_v[r][c] = 9'(v);
    endtask

    task automatic point(input int v);
        fill(0);
        blk_v[0][0] = 9'(v);
    endtask

    task automatic exp_dc(input int v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) exp_z[r][c] = 0;
        exp_z[0][0] = v;
    endtask

    task automatic start_block(input logic [5:0] qp, input logic [3:0] idx);
        @(negedge clk);
        check("ready_idle", 32'(res_ready_o), 1);
        res_i = blk_v; qp_i = qp; blk_idx_i = idx; res_valid_i = 1'b1;
        @(posedge clk); #1;
        res_valid_i = 1'b0;
        check("ready_busy", 32'(res_ready_o), 0);
    endtask

    task automatic run_block(input logic [5:0] qp, input logic [3:0] idx, input int nz);
        start_block(qp, idx);
        repeat (11) @(posedge clk);
        #1 check("valid_early", 32'(coef_valid_o), 0);
        @(posedge clk); #1;
        check("valid_at_12", 32'(coef_valid_o), 1);
        check("blk_idx", 32'(coef_blk_idx_o), 32'(idx));
        check("nz", 32'(coef_nz_o), nz);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                check($sformatf("coef[%0d][%0d]", r, c), 32'($signed(coef_o[r][c])), exp_z[r][c]);
    endtask

    task automatic release_block();
        @(negedge clk);
        coef_ready_i = 1'b1;
        @(posedge clk); #1;
        coef_ready_i = 1'b0;
        check("valid_drop", 32'(coef_valid_o), 0);
        check("ready_back", 32'(res_ready_o), 1);
    endtask

    initial begin
        rst = 1'b0; res_valid_i = 1'b0; res_i = '0; blk_idx_i = '0; qp_i = '0; coef_ready_i = 1'b0;
        blk_v = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(res_ready_o), 0);
        check("rst_valid", 32'(coef_valid_o), 0);
        check("rst_nz", 32'(coef_nz_o), 0);
        check("rst_idx", 32'(coef_blk_idx_o), 0);
        check("rst_coef_zero", 32'(coef_o == '0), 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(res_ready_o), 1);

        fill(0);   exp_dc(0);  run_block(6'd27, 4'd3, 0);  release_block();
        fill(10);  exp_dc(3);  run_block(6'd27, 4'd5, 1);  release_block();
        fill(-10); exp_dc(-3); run_block(6'd27, 4'd6, 1);  release_block();
        fill(1);   exp_dc(6);  run_block(6'd0,  4'd7, 1);  release_block();
        fill(1);   exp_dc(0);  run_block(6'd60, 4'd8, 0);  release_block();

        point(100);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) exp_z[r][c] = tab_a[r][c];
        run_block(6'd28, 4'd10, 15); release_block();
        point(-100);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) exp_z[r][c] = -tab_a[r][c];
        run_block(6'd28, 4'd11, 15); release_block();

        // Backpressure: output must hold while new blocks are offered.
        point(10);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) exp_z[r][c] = tab_b[r][c];
        run_block(6'd5, 4'd12, 16);
        fill(7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            res_i = blk_v; qp_i = 6'd0; blk_idx_i = 4'd1; res_valid_i = ~res_valid_i;
            @(posedge clk); #1;
            check("hold_valid", 32'(coef_valid_o), 1);
            check("hold_ready", 32'(res_ready_o), 0);
            check("hold_nz", 32'(coef_nz_o), 16);
            check("hold_idx", 32'(coef_blk_idx_o), 12);
            check("hold_c11", 32'($signed(coef_o[1][1])), 3);
            check("hold_c33", 32'($signed(coef_o[3][3])), 1);
        end
        @(negedge clk) res_valid_i = 1'b0;
        release_block();
        @(posedge clk); #1;
        check("no_stray_accept", 32'(res_ready_o), 1);

        // Abort during COL; the previous block's coefficients must clear at once.
        point(10);
        start_block(6'd5, 4'd9);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        check("abort_valid", 32'(coef_valid_o), 0);
        check("abort_ready", 32'(res_ready_o), 0);
        check("abort_idx", 32'(coef_blk_idx_o), 0);
        check("abort_coef_zero", 32'(coef_o == '0), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_abort", 32'(res_ready_o), 1);
        fill(10); exp_dc(3); run_block(6'd27, 4'd2, 1); release_block();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
